vend_ctrl_param: RTL
====================

// Module: vend_ctrl_param
// PURPOSE
//  Parametrised vending controller: debounced half/one coin keys, cancel key, configurable
//  price, serial change/refund dispensing and LED status. Replaces the fixed 2.5-unit
//  top-level vending chain with one block. It sits between the raw board keys and the
//  dispenser/LED pins.
// PARAMETERS
//  DEB_CYCLES  1_000_000  consecutive stable synced cycles before a key level is accepted (>=2)
//  PRICE       5          item price in half-units (>=2)
//  CW          4          credit/change counter width; must satisfy PRICE+2 < 2**CW
//  CHG_GAP     25_000_000 cycles between successive po_money pulses (>=2)
// PORTS
//  sys_clk        in   1   system clock
//  sys_rst        in   1   synchronous reset, active-high
//  pi_money_half  in   1   raw key, active-low, asynchronous, bouncy: 1 half-unit coin
//  pi_money_one   in   1   raw key, active-low, asynchronous, bouncy: 2 half-unit coin
//  pi_cancel      in   1   raw key, active-low, asynchronous, bouncy: refund request
//  po_cola        out  1   1-cycle pulse: item dispensed
//  po_money       out  1   1-cycle pulse: one half-unit of change/refund returned
//  po_reject      out  1   1-cycle pulse: coin arrived while busy and is not credited
//  credit         out  CW  current credit in half-units
//  state          out  3   FSM state: IDLE=0, COLLECT=1, VEND=2, CHANGE=3
//  led            out  4   status display
// BEHAVIOUR
//  Reset (all sync, sys_rst=1): all outputs 0, FSM=IDLE, credit=0, change count=0.
//   Synchroniser flops and filtered key levels are set to 1 (released). A key held through
//   reset counts as one press once it has been debounced. Reset mid-CHANGE drops pending change.
//  Key path, per key:
//   - 2-flop synchroniser, then a stability counter.
//   - Filtered level takes the synced value after DEB_CYCLES consecutive equal cycles.
//   - A 1->0 filtered transition yields a 1-cycle internal press pulse.
//   - Press pulse latency from a clean raw edge is exactly DEB_CYCLES+3 cycles.
//   - Glitches shorter than DEB_CYCLES produce no pulse. Release produces no pulse.
//  Coin value per cycle: v = half + 2*one (0..3). Simultaneous half+one pulses credit 3.
//  FSM, evaluated each cycle with press pulses from cycle t, results visible at t+1:
//   IDLE/COLLECT, no cancel:
//    - credit <= credit+v.
//    - If credit+v >= PRICE -> VEND, change <= credit+v-PRICE.
//    - Else if credit+v > 0 -> COLLECT.
//    - Else stay.
//   COLLECT with cancel press:
//    - Cancel wins over any same-cycle coin; that coin raises po_reject.
//    - change <= credit, credit <= 0, -> CHANGE.
//   IDLE with cancel press: ignored.
//   VEND, exactly 1 cycle:
//    - po_cola=1, credit <= 0.
//    - change>0 -> CHANGE, else -> IDLE.
//   CHANGE:
//    - Gap counter starts at 0 on entry.
//    - po_money=1 on cycles where gap==0, and change decrements on those cycles.
//    - gap wraps at CHG_GAP-1.
//    - After the pulse that takes change to 0, next state is IDLE.
//  Busy states:
//   - Any coin press in VEND or CHANGE gives po_reject=1 in the same cycle as po_cola/po_money
//     would appear (t+1); credit is unchanged.
//   - Cancel presses in VEND or CHANGE are ignored.
//  Max transient credit is PRICE+2, so there is no overflow. Credit never wraps.
//  Outputs are registered. po_* pulses are exactly 1 cycle wide.
//  LED by state:
//   IDLE    = 0000
//   COLLECT = credit[3:0]
//   VEND    = 1111
//   CHANGE  = {1'b1, change[2:0]}
// TESTING (DEB_CYCLES=4, PRICE=5, CHG_GAP=3)
//  1. Press one,one,half, each clean, with gaps:
//     credit steps 2,4 then VEND, po_cola=1 once, no po_money, back to IDLE.
//  2. Half+one pressed in the same cycle at credit 4:
//     credit 7 -> VEND, then 2 po_money pulses 3 cycles apart, then IDLE.
//  3. Half key bounces 0/1 every 2 cycles for 20 cycles then settles low:
//     exactly one credit increment, DEB_CYCLES+3 cycles after the final edge.
//  4. Credit 3, cancel pressed together with a one coin:
//     po_reject=1, 3 po_money pulses, credit 0, po_cola never asserted.
//  5. One coin during CHANGE:
//     po_reject=1, change sequence and count unaffected.
//  6. sys_rst asserted mid-CHANGE with 2 units pending:
//     next cycle all outputs 0, state IDLE, no further po_money.

Source files
------------

// File: rtl/vend_ctrl_param.sv
// Purpose: debounced-key vending controller with a configurable price, serial change/refund and LED status.
// Latency: key edge to press pulse is DEB_CYCLES+3 cycles; FSM reacts one cycle after a press; all outputs registered.
// Backpressure: none; coins arriving in VEND/CHANGE are refused with a po_reject pulse instead of being queued.
//
// Ports:
//   sys_clk, sys_rst                       clock, synchronous active-high reset
//   pi_money_half, pi_money_one, pi_cancel raw active-low asynchronous bouncy keys
//   po_cola, po_money, po_reject           single-cycle event pulses
//   credit [CW-1:0], state [2:0], led [3:0] status outputs
module vend_ctrl_param #(
    parameter int DEB_CYCLES = 1_000_000,
    parameter int PRICE      = 5,
    parameter int CW         = 4,
    parameter int CHG_GAP    = 25_000_000
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    input  logic          pi_money_half,
    input  logic          pi_money_one,
    input  logic          pi_cancel,
    output logic          po_cola,
    output logic          po_money,
    output logic          po_reject,
    output logic [CW-1:0] credit,
    output logic [2:0]    state,
    output logic [3:0]    led
);

    localparam int DW = $clog2(DEB_CYCLES);
    localparam int GW = $clog2(CHG_GAP);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COLLECT = 3'd1,
        S_VEND    = 3'd2,
        S_CHANGE  = 3'd3
    } state_t;

    // ------------------------------------------------------------------
    // Key conditioning. Bit order everywhere: {cancel, one, half}.
    // ------------------------------------------------------------------
    logic [2:0]    raw_keys;
    logic [2:0]    sync1_q, sync2_q, filt_q, press_q;
    logic [DW-1:0] cnt_q [3];

    assign raw_keys = {pi_cancel, pi_money_one, pi_money_half};

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sync1_q <= '1;
            sync2_q <= '1;
            filt_q  <= '1;
            press_q <= '0;
            for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q <= raw_keys;
            sync2_q <= sync1_q;
            for (int i = 0; i < 3; i++) begin
                press_q[i] <= 1'b0;
                if (sync2_q[i] == filt_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == DW'(DEB_CYCLES - 1)) begin
                    // This is the DEB_CYCLES-th consecutive differing cycle: accept the level.
                    // A differing level while filt is high can only be a press (1->0).
                    filt_q[i]  <= sync2_q[i];
                    cnt_q[i]   <= '0;
                    press_q[i] <= filt_q[i];
                end else begin
                    cnt_q[i] <= cnt_q[i] + DW'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Vending FSM
    // ------------------------------------------------------------------
    state_t        state_q, state_d;
    logic [CW-1:0] credit_q, credit_d;
    logic [CW-1:0] change_q, change_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          cola_q, cola_d;
    logic          money_q, money_d;
    logic          reject_q, reject_d;
    logic [3:0]    led_q, led_d;

    logic [CW-1:0] coin_v;
    logic [CW-1:0] sum;
    logic          coin_any;
    logic          cancel_p;
    logic [CW+3:0] credit_ext;

    // half is worth 1, one is worth 2, so the coin value is simply {one, half}.
    assign coin_v   = CW'({press_q[1], press_q[0]});
    assign sum      = credit_q + coin_v;
    assign coin_any = press_q[0] | press_q[1];
    assign cancel_p = press_q[2];

    always_comb begin
        state_d    = state_q;
        credit_d   = credit_q;
        change_d   = change_q;
        gap_d      = '0;
        cola_d     = 1'b0;
        money_d    = 1'b0;
        reject_d   = 1'b0;
        led_d      = 4'b0000;
        credit_ext = '0;

        case (state_q)
            S_IDLE, S_COLLECT: begin
                if (state_q == S_COLLECT && cancel_p) begin
                    // Cancel beats a same-cycle coin; that coin is refused.
                    change_d = credit_q;
                    credit_d = '0;
                    state_d  = S_CHANGE;
                    reject_d = coin_any;
                end else begin
                    credit_d = sum;
                    if (sum >= CW'(PRICE)) begin
                        state_d  = S_VEND;
                        change_d = sum - CW'(PRICE);
                    end else if (sum != '0) begin
                        state_d = S_COLLECT;
                    end
                end
            end
            S_VEND: begin
                cola_d   = 1'b1;
                credit_d = '0;
                reject_d = coin_any;
                state_d  = (change_q != '0) ? S_CHANGE : S_IDLE;
            end
            S_CHANGE: begin
                reject_d = coin_any;
                if (gap_q == '0) begin
                    money_d  = 1'b1;
                    change_d = change_q - CW'(1);
                    if (change_q == CW'(1)) state_d = S_IDLE;
                end
                gap_d = (gap_q == GW'(CHG_GAP - 1)) ? '0 : gap_q + GW'(1);
            end
            default: state_d = S_IDLE;
        endcase

        // LED tracks the state being entered so it is coherent with state/credit.
        credit_ext = {4'b0000, credit_d};
        case (state_d)
            S_COLLECT: led_d = credit_ext[3:0];
            S_VEND:    led_d = 4'b1111;
            S_CHANGE:  led_d = {1'b1, change_d[2:0]};
            default:   led_d = 4'b0000;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q  <= S_IDLE;
            credit_q <= '0;
            change_q <= '0;
            gap_q    <= '0;
            cola_q   <= 1'b0;
            money_q  <= 1'b0;
            reject_q <= 1'b0;
            led_q    <= 4'b0000;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            change_q <= change_d;
            gap_q    <= gap_d;
            cola_q   <= cola_d;
            money_q  <= money_d;
            reject_q <= reject_d;
            led_q    <= led_d;
        end
    end

    assign po_cola   = cola_q;
    assign po_money  = money_q;
    assign po_reject = reject_q;
    assign credit    = credit_q;
    assign state     = state_q;
    assign led       = led_q;

endmodule
